bram_port_arb: RTL and testbench
================================

BRAM_PORT_ARB -- requirements
Module: bram_port_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of the BRAM data words (multiple of 8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, width of the BRAM address.
REQ-003 SHALL have parameter NUM_CH, default 4, number of requester channels (1..16).
REQ-004 SHALL have parameter RD_LATENCY, default 1, BRAM read latency in cycles (1..4).
REQ-005 SHALL have port Clk_CI, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port Rst_RBI, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port Req_SI, input, NUM_CH bits, per-channel access request.
REQ-008 SHALL have port Gnt_SO, output, NUM_CH bits, per-channel grant; a transfer occurs when Req_SI[i] and Gnt_SO[i] are both high.
REQ-009 SHALL have port Addr_DI, input, NUM_CH*ADDR_WIDTH bits, per-channel address.
REQ-010 SHALL have port Wr_DI, input, NUM_CH*DATA_WIDTH bits, per-channel write data.
REQ-011 SHALL have port WrEn_SI, input, NUM_CH*DATA_WIDTH/8 bits, per-channel byte write enables; all-zero means read.
REQ-012 SHALL have port RdValid_SO, output, NUM_CH bits, per-channel read-data valid strobe.
REQ-013 SHALL have port Rd_DO, output, NUM_CH*DATA_WIDTH bits, per-channel read data.
REQ-014 SHALL have ports En_SO (1), Addr_SO (ADDR_WIDTH), Wr_DO (DATA_WIDTH) and WrEn_SO (DATA_WIDTH/8), all outputs, forming the BRAM command side.
REQ-015 SHALL have port Rd_DI, input, DATA_WIDTH bits, BRAM read data.

Function
REQ-016 SHALL assert at most one Gnt_SO bit per cycle, and only for a channel with Req_SI high; Gnt_SO is combinational from Req_SI and the priority pointer.
REQ-017 SHALL arbitrate round-robin: a priority pointer Ptr (0..NUM_CH-1) names the highest-priority channel, and the granted channel is the first requesting channel at or after Ptr, modulo NUM_CH.
REQ-018 SHALL update Ptr to (granted index + 1) mod NUM_CH on every cycle with a grant, and hold Ptr otherwise.
REQ-019 SHALL drive En_SO high, and Addr_SO, Wr_DO and WrEn_SO from the granted channel, in the grant cycle; with no grant, En_SO=0 and WrEn_SO=0.
REQ-020 SHALL track reads (granted transfer with WrEn all-zero) in a RD_LATENCY-deep pipeline of {valid, channel index}.
REQ-021 SHALL assert RdValid_SO[c] exactly RD_LATENCY cycles after the grant cycle of a read from channel c, for exactly one cycle.
REQ-022 SHALL drive Rd_DO[c] = Rd_DI while RdValid_SO[c] is high, else zero; other channels' Rd_DO are zero.
REQ-023 SHALL NOT produce a RdValid_SO pulse for a write; a write sets only the byte lanes enabled in WrEn.
REQ-024 SHALL accept back-to-back transfers every cycle (throughput 1 per cycle), including a read granted every cycle with RD_LATENCY reads in flight.
REQ-025 SHALL let a requester drop Req_SI without a grant (no lock); a channel that never requests never stalls others.
REQ-026 SHALL grant channel 0 whenever NUM_CH=1 and Req_SI[0] is high, independent of Ptr.

Reset
REQ-027 SHALL, while Rst_RBI is low, asynchronously clear Ptr to 0 and every read-pipeline valid bit to 0.
REQ-028 SHALL hold Gnt_SO=0, En_SO=0, WrEn_SO=0, RdValid_SO=0 and Rd_DO=0 while Rst_RBI is low.
REQ-029 SHALL discard reads in flight when reset asserts mid-operation; no RdValid_SO pulse appears for them after reset releases.
REQ-030 SHALL accept a grant on the first rising edge after Rst_RBI deasserts.

Verification
REQ-031 After reset, Req_SI=4'b1111 held for 8 cycles -> grants in the order 0,1,2,3,0,1,2,3, one per cycle, with En_SO high every cycle.
REQ-032 Ch2 reads address 0x10, RD_LATENCY=3, and the BRAM model returns 0xDEADBEEF -> RdValid_SO=4'b0100 exactly 3 cycles after the grant, Rd_DO[2]=0xDEADBEEF, and all other Rd_DO are 0.
REQ-033 Ch1 writes 0xAABBCCDD with WrEn=4'b0101, then reads back -> the model holds 0x00BB00DD over an initial 0, and no RdValid_SO pulse is produced for the write.
REQ-034 Ptr=2 with only ch0 and ch3 requesting -> ch3 is granted first, then ch0.
REQ-035 Reset pulsed low one cycle after two reads are granted -> no RdValid_SO pulse at any later cycle, and Ptr=0.
REQ-036 Random requests for 10k cycles against a reference model -> no double grant, no starvation beyond NUM_CH-1 cycles, and every read matched by exactly one RdValid_SO pulse.

Source files
------------

// File: rtl/bram_port_arb.sv
// Round-robin arbiter multiplexing NUM_CH requesters onto a single BRAM port.
// Read data is steered back to the issuing channel RD_LATENCY cycles after its grant.
module bram_port_arb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                           Clk_CI,
  input  logic                           Rst_RBI,
  input  logic [NUM_CH-1:0]              Req_SI,
  output logic [NUM_CH-1:0]              Gnt_SO,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   Addr_DI,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   Wr_DI,
  input  logic [NUM_CH*DATA_WIDTH/8-1:0] WrEn_SI,
  output logic [NUM_CH-1:0]              RdValid_SO,
  output logic [NUM_CH*DATA_WIDTH-1:0]   Rd_DO,
  output logic                           En_SO,
  output logic [ADDR_WIDTH-1:0]          Addr_SO,
  output logic [DATA_WIDTH-1:0]          Wr_DO,
  output logic [DATA_WIDTH/8-1:0]        WrEn_SO,
  input  logic [DATA_WIDTH-1:0]          Rd_DI
);

  localparam int unsigned BeW  = DATA_WIDTH / 8;
  localparam int unsigned IdxW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [IdxW-1:0]       ptr_q, ptr_d;
  logic [IdxW-1:0]       gnt_idx;
  logic                  gnt_any;
  logic [BeW-1:0]        wr_en_sel;
  logic                  rd_push;
  logic [RD_LATENCY-1:0] rd_vld_q;
  logic [IdxW-1:0]       rd_idx_q [RD_LATENCY];

  // Scan channels starting at the pointer; the first requester wins.
  always_comb begin
    int unsigned cand;
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= NUM_CH) begin
        cand = cand - NUM_CH;
      end
      if (Rst_RBI && !gnt_any && Req_SI[cand[IdxW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[IdxW-1:0];
      end
    end
  end

  always_comb begin
    Gnt_SO = '0;
    if (gnt_any) begin
      Gnt_SO[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    wr_en_sel = WrEn_SI[32'(gnt_idx)*BeW +: BeW];
    En_SO     = gnt_any;
    Addr_SO   = '0;
    Wr_DO     = '0;
    WrEn_SO   = '0;
    if (gnt_any) begin
      Addr_SO = Addr_DI[32'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      Wr_DO   = Wr_DI[32'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
      WrEn_SO = wr_en_sel;
    end
  end

  assign rd_push = gnt_any && (wr_en_sel == '0);

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (gnt_idx == IdxW'(NUM_CH - 1)) ? '0 : gnt_idx + IdxW'(1);
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      ptr_q    <= '0;
      rd_vld_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        rd_idx_q[i] <= '0;
      end
    end else begin
      ptr_q       <= ptr_d;
      rd_vld_q[0] <= rd_push;
      rd_idx_q[0] <= gnt_idx;
      for (int i = 1; i < RD_LATENCY; i++) begin
        rd_vld_q[i] <= rd_vld_q[i-1];
        rd_idx_q[i] <= rd_idx_q[i-1];
      end
    end
  end

  // The last pipeline stage lines up with the BRAM output word.
  always_comb begin
    RdValid_SO = '0;
    Rd_DO      = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (rd_vld_q[RD_LATENCY-1] && (rd_idx_q[RD_LATENCY-1] == IdxW'(c))) begin
        RdValid_SO[c]                     = 1'b1;
        Rd_DO[c*DATA_WIDTH +: DATA_WIDTH] = Rd_DI;
      end
    end
  end

endmodule

// File: tb/tb_bram_port_arb.sv
// Bench for bram_port_arb: directed scenarios plus random traffic checked against
// a transaction-level model of arbitration, BRAM contents and read return timing.
module tb_bram_port_arb;

  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int LAT = 3;

  typedef struct {
    int          due;
    int          ch;
    logic [31:0] data;
  } pend_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NCH-1:0]      req;
  logic [AW-1:0]       addr_a [NCH];
  logic [DW-1:0]       wdat_a [NCH];
  logic [DW/8-1:0]     wen_a  [NCH];
  logic [NCH*AW-1:0]   addr_bus;
  logic [NCH*DW-1:0]   wdat_bus;
  logic [NCH*DW/8-1:0] wen_bus;
  logic [NCH-1:0]      gnt, rdv;
  logic [NCH*DW-1:0]   rd_do;
  logic                en_so;
  logic [AW-1:0]       addr_so;
  logic [DW-1:0]       wr_do;
  logic [DW/8-1:0]     wren_so;
  logic [DW-1:0]       rd_di;

  logic [31:0] bram [64];
  logic [31:0] sh   [LAT];
  logic [31:0] ref_mem [64];
  pend_t       pend [$];
  int          m_ptr;
  int          cyc;
  int          n_err;
  int          n_chk;
  int          wait_c [NCH];
  logic [3:0]  obs_gnt, obs_rv;
  logic        obs_en;
  logic [31:0] obs_rd [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_pack
    assign addr_bus[g*AW +: AW]     = addr_a[g];
    assign wdat_bus[g*DW +: DW]     = wdat_a[g];
    assign wen_bus[g*DW/8 +: DW/8]  = wen_a[g];
  end

  bram_port_arb #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .NUM_CH    (NCH),
    .RD_LATENCY(LAT)
  ) u_dut (
    .Clk_CI    (clk),
    .Rst_RBI   (rst_n),
    .Req_SI    (req),
    .Gnt_SO    (gnt),
    .Addr_DI   (addr_bus),
    .Wr_DI     (wdat_bus),
    .WrEn_SI   (wen_bus),
    .RdValid_SO(rdv),
    .Rd_DO     (rd_do),
    .En_SO     (en_so),
    .Addr_SO   (addr_so),
    .Wr_DO     (wr_do),
    .WrEn_SO   (wren_so),
    .Rd_DI     (rd_di)
  );

  always #5 clk = ~clk;

  // BRAM with a LAT-cycle registered read path.
  assign rd_di = sh[LAT-1];
  always @(posedge clk) begin
    if (en_so && wren_so == 4'h0) begin
      sh[0] <= bram[addr_so[5:0]];
    end else begin
      sh[0] <= 32'h0;
    end
    if (en_so) begin
      for (int b = 0; b < 4; b++) begin
        if (wren_so[b]) bram[addr_so[5:0]][8*b +: 8] <= wr_do[8*b +: 8];
      end
    end
    for (int i = 1; i < LAT; i++) sh[i] <= sh[i-1];
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: sample at negedge, compare with the model, advance the model.
  task automatic step();
    int          eg;
    int          best;
    int          d;
    logic [3:0]  erv;
    logic [31:0] erd [NCH];
    @(negedge clk);
    obs_gnt = gnt;
    obs_rv  = rdv;
    obs_en  = en_so;
    for (int c = 0; c < NCH; c++) obs_rd[c] = rd_do[c*DW +: DW];
    if (!rst_n) begin
      pend.delete();
      m_ptr = 0;
    end
    eg   = -1;
    best = NCH;
    if (rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        if (req[c]) begin
          d = (c - m_ptr + NCH) % NCH;
          if (d < best) begin
            best = d;
            eg   = c;
          end
        end
      end
    end
    erv = 4'h0;
    for (int c = 0; c < NCH; c++) erd[c] = 32'h0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      erv[pend[0].ch] = 1'b1;
      erd[pend[0].ch] = pend[0].data;
      void'(pend.pop_front());
    end
    check_eq("gnt", obs_gnt, (eg >= 0) ? (4'b0001 << eg) : 4'b0000);
    check_eq("en", obs_en, eg >= 0);
    if (eg >= 0) begin
      check_eq("wren", wren_so, wen_a[eg]);
      check_eq("addr", addr_so, addr_a[eg]);
      check_eq("wdat", wr_do, wdat_a[eg]);
    end else begin
      check_eq("wren_idle", wren_so, 4'h0);
    end
    check_eq("rdvalid", obs_rv, erv);
    for (int c = 0; c < NCH; c++) check_eq("rd_do", obs_rd[c], erd[c]);
    for (int c = 0; c < NCH; c++) begin
      if (rst_n && req[c] && !obs_gnt[c]) wait_c[c]++;
      else wait_c[c] = 0;
      if (req[c]) check_eq("starve", wait_c[c] > NCH - 1, 1'b0);
    end
    if (eg >= 0) begin
      m_ptr = (eg + 1) % NCH;
      if (wen_a[eg] == 4'h0) begin
        pend.push_back('{due: cyc + LAT, ch: eg, data: ref_mem[addr_a[eg][5:0]]});
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (wen_a[eg][b]) ref_mem[addr_a[eg][5:0]][8*b +: 8] = wdat_a[eg][8*b +: 8];
        end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    req = 4'h0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    n_err = 0;
    n_chk = 0;
    cyc   = 0;
    m_ptr = 0;
    rst_n = 1'b0;
    req   = 4'h0;
    for (int i = 0; i < 64; i++) begin
      bram[i]    = 32'h0;
      ref_mem[i] = 32'h0;
    end
    for (int i = 0; i < LAT; i++) sh[i] = 32'h0;
    for (int c = 0; c < NCH; c++) begin
      addr_a[c] = 32'h0;
      wdat_a[c] = 32'h0;
      wen_a[c]  = 4'h0;
      wait_c[c] = 0;
    end

    // Reset holds every output low even with all channels requesting.
    step();
    req = 4'hF;
    step();
    check_eq("rst_gnt", obs_gnt, 4'h0);
    check_eq("rst_en", obs_en, 1'b0);
    rst_n = 1'b1;

    // All channels requesting: strict rotation starting from channel 0.
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq("rr_order", obs_gnt, 4'b0001 << (i % 4));
      check_eq("rr_en", obs_en, 1'b1);
    end
    idle(LAT + 2);

    // Ch0 writes 0xDEADBEEF at 0x10, ch2 reads it back after LAT cycles.
    req = 4'b0001; addr_a[0] = 32'h10; wdat_a[0] = 32'hDEADBEEF; wen_a[0] = 4'hF;
    step();
    req = 4'b0100; addr_a[2] = 32'h10; wen_a[2] = 4'h0;
    step();
    check_eq("rd_gnt", obs_gnt, 4'b0100);
    req = 4'h0;
    step();
    step();
    step();
    check_eq("rd_valid", obs_rv, 4'b0100);
    check_eq("rd_data2", obs_rd[2], 32'hDEADBEEF);
    check_eq("rd_data0", obs_rd[0], 32'h0);
    check_eq("rd_data1", obs_rd[1], 32'h0);
    check_eq("rd_data3", obs_rd[3], 32'h0);
    idle(2);

    // Ch1 partial write over zero, then read back.
    req = 4'b0010; addr_a[1] = 32'h20; wdat_a[1] = 32'hAABBCCDD; wen_a[1] = 4'b0101;
    step();
    req = 4'h0;
    for (int i = 0; i < LAT + 1; i++) begin
      step();
      check_eq("wr_no_valid", obs_rv, 4'h0);
    end
    req = 4'b0010; wen_a[1] = 4'h0;
    step();
    req = 4'h0;
    step();
    step();
    step();
    check_eq("bw_valid", obs_rv, 4'b0010);
    check_eq("bw_data", obs_rd[1], 32'h00BB00DD);

    // Pointer now at 2 (last grant ch1): ch3 beats ch0, then ch0.
    req = 4'b1001; wen_a[0] = 4'h0; wen_a[3] = 4'h0;
    step();
    check_eq("ptr2_first", obs_gnt, 4'b1000);
    step();
    check_eq("ptr2_second", obs_gnt, 4'b0001);
    idle(LAT + 2);

    // Two reads in flight, then a reset pulse: both reads are dropped.
    req = 4'b0011; wen_a[0] = 4'h0; wen_a[1] = 4'h0;
    step();
    step();
    rst_n = 1'b0;
    req   = 4'h0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < LAT + 2; i++) begin
      step();
      check_eq("flush_valid", obs_rv, 4'h0);
    end
    req = 4'hF;
    step();
    check_eq("ptr_after_rst", obs_gnt, 4'b0001);
    idle(LAT + 2);

    // Random traffic against the model.
    for (int i = 0; i < 10000; i++) begin
      req = 4'($urandom_range(0, 15));
      for (int c = 0; c < NCH; c++) begin
        addr_a[c] = 32'($urandom_range(0, 63));
        wdat_a[c] = $urandom;
        wen_a[c]  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      end
      step();
    end
    idle(LAT + 2);
    check_eq("pend_drained", pend.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
